// File: rtl/uart_echo_top.sv
`default_nettype none
// ============================================================================
// uart_echo_top: 8N1 UART loopback. Shows the last good byte on the LEDs and
// retransmits it through a one-entry, last-wins holding register.
// Revision: 1.0
// ============================================================================
module uart_echo_top #(
  parameter int BIT_DIV       = 1250,
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic       ice_clk_i,
  input  logic       rstn_i,
  input  logic       rs232_rx_i,
  output logic [7:0] led_o,
  output logic       rs232_tx_o
);

  localparam int c_RX_DIV = BIT_DIV / RX_OVERSAMPLE;
  localparam int c_TX_W   = $clog2(BIT_DIV);
  localparam int c_RX_W   = $clog2(c_RX_DIV);
  localparam int c_OS_W   = $clog2(RX_OVERSAMPLE);
  localparam logic [c_OS_W-1:0] c_OS_MID  = c_OS_W'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(RX_OVERSAMPLE - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_STOP} tx_state_t;

  logic [c_TX_W-1:0] r_tx_div;
  logic [c_RX_W-1:0] r_rx_div;
  logic              w_tx_tick;
  logic              w_rx_tick;

  logic              r_rx_meta;
  logic              r_rx_sync;

  rx_state_t         r_rx_state, w_rx_state_nxt;
  logic [c_OS_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]        r_rx_idx, w_rx_idx_nxt;
  logic [7:0]        r_rx_shift, w_rx_shift_nxt;
  logic              r_rx_wait, w_rx_wait_nxt;
  logic              w_rx_valid;

  logic [7:0]        r_led;
  logic [7:0]        r_hold_data;
  logic              r_hold_full;

  tx_state_t         r_tx_state, w_tx_state_nxt;
  logic [2:0]        r_tx_idx, w_tx_idx_nxt;
  logic [7:0]        r_tx_shift, w_tx_shift_nxt;
  logic              r_tx_line, w_tx_line_nxt;
  logic              w_tx_load;

  assign w_tx_tick = (r_tx_div == c_TX_W'(BIT_DIV - 1));
  assign w_rx_tick = (r_rx_div == c_RX_W'(c_RX_DIV - 1));

  always_ff @(posedge ice_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tx_div <= '0;
      r_rx_div <= '0;
    end else begin
      r_tx_div <= w_tx_tick ? '0 : r_tx_div + c_TX_W'(1);
      r_rx_div <= w_rx_tick ? '0 : r_rx_div + c_RX_W'(1);
    end
  end

  always_ff @(posedge ice_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rs232_rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end

  // After a framing error r_rx_wait blocks start detection until the line idles high.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_wait_nxt  = r_rx_wait;
    w_rx_valid     = 1'b0;
    if (w_rx_tick) begin
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_sync) begin
            w_rx_wait_nxt = 1'b0;
          end else if (!r_rx_wait) begin
            w_rx_state_nxt = RX_START;
            w_rx_cnt_nxt   = '0;
          end
        end
        RX_START: begin
          w_rx_cnt_nxt = r_rx_cnt + c_OS_W'(1);
          if (r_rx_cnt == c_OS_MID) begin
            w_rx_cnt_nxt   = '0;
            w_rx_idx_nxt   = '0;
            w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          w_rx_cnt_nxt = r_rx_cnt + c_OS_W'(1);
          if (r_rx_cnt == c_OS_LAST) begin
            w_rx_cnt_nxt   = '0;
            w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
            w_rx_idx_nxt   = r_rx_idx + 3'd1;
            if (r_rx_idx == 3'd7) w_rx_state_nxt = RX_STOP;
          end
        end
        RX_STOP: begin
          w_rx_cnt_nxt = r_rx_cnt + c_OS_W'(1);
          if (r_rx_cnt == c_OS_LAST) begin
            w_rx_cnt_nxt   = '0;
            w_rx_state_nxt = RX_IDLE;
            if (r_rx_sync) w_rx_valid    = 1'b1;
            else           w_rx_wait_nxt = 1'b1;
          end
        end
        default: w_rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge ice_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_wait  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_wait  <= w_rx_wait_nxt;
    end
  end

  // A new byte wins over a same-cycle load; the shifter takes the older byte.
  always_ff @(posedge ice_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_led       <= '0;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
    end else if (w_rx_valid) begin
      r_led       <= r_rx_shift;
      r_hold_data <= r_rx_shift;
      r_hold_full <= 1'b1;
    end else if (w_tx_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_line_nxt  = r_tx_line;
    w_tx_load      = 1'b0;
    if (w_tx_tick) begin
      case (r_tx_state)
        TX_IDLE: begin
          if (r_hold_full) begin
            w_tx_load      = 1'b1;
            w_tx_shift_nxt = r_hold_data;
            w_tx_idx_nxt   = '0;
            w_tx_line_nxt  = 1'b0;
            w_tx_state_nxt = TX_DATA;
          end
        end
        TX_DATA: begin
          w_tx_line_nxt  = r_tx_shift[0];
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_idx_nxt   = r_tx_idx + 3'd1;
          if (r_tx_idx == 3'd7) w_tx_state_nxt = TX_STOP;
        end
        TX_STOP: begin
          w_tx_line_nxt  = 1'b1;
          w_tx_state_nxt = TX_IDLE;
        end
        default: w_tx_state_nxt = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge ice_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_line  <= w_tx_line_nxt;
    end
  end

  assign led_o      = r_led;
  assign rs232_tx_o = r_tx_line;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_top.sv
`default_nettype none
// tb_uart_echo_top: table-driven RX/LED checks plus a scoreboard that decodes
// every echoed TX frame and compares it with the bytes that were sent.
module tb_uart_echo_top;

  localparam int BIT_DIV       = 100;
  localparam int RX_OVERSAMPLE = 16;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] led;
  logic       tx;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_led;
  } vec_t;

  vec_t tbl[7];

  uart_echo_top #(
    .BIT_DIV      (BIT_DIV),
    .RX_OVERSAMPLE(RX_OVERSAMPLE)
  ) dut (
    .ice_clk_i (clk),
    .rstn_i    (rstn),
    .rs232_rx_i(rx),
    .led_o     (led),
    .rs232_tx_o(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame starting at a falling clock edge; returns on a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BIT_DIV) @(negedge clk);
    end
  endtask

  task automatic drain(input string name, input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // TX monitor: decode each frame at bit centres, abandon it if reset hits.
  initial begin : mon
    logic [9:0] f;
    logic [7:0] e;
    bit         abort;
    forever begin
      @(negedge clk);
      if (rstn && tx === 1'b0) begin
        abort = 1'b0;
        f     = '0;
        for (int b = 0; b < 10 && !abort; b++) begin
          repeat (b == 0 ? BIT_DIV / 2 : BIT_DIV) begin
            @(negedge clk);
            if (!rstn) abort = 1'b1;
          end
          f[b] = tx;
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL echo_unexpected: got frame %0h expected no frame", f);
          end else begin
            e = exp_q.pop_front();
            check("echo_frame", {22'd0, f}, {22'd0, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  initial begin : main
    int bad;
    int k;
    tbl[0] = '{8'h48, 1'b1, 8'h48};
    tbl[1] = '{8'h00, 1'b1, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF};
    tbl[3] = '{8'h55, 1'b0, 8'hFF};
    tbl[4] = '{8'hA5, 1'b1, 8'hA5};
    tbl[5] = '{8'h01, 1'b1, 8'h01};
    tbl[6] = '{8'h80, 1'b1, 8'h80};

    bad = 0;
    repeat (625) begin
      @(negedge clk);
      if (tx !== 1'b1 || led !== 8'h00) bad++;
    end
    check("reset_hold", bad, 0);
    rstn = 1'b1;
    bad  = 0;
    repeat (20 * BIT_DIV) begin
      @(negedge clk);
      if (tx !== 1'b1 || led !== 8'h00) bad++;
    end
    check("idle_after_reset", bad, 0);

    // Single byte: LED latency, start-bit latency and start+3 zero bits width.
    exp_q.push_back(8'h48);
    fork
      send_frame(8'h48, 1'b1);
      begin
        k = 0;
        while (led !== 8'h48 && k < 11 * BIT_DIV) begin
          @(negedge clk);
          k++;
        end
        check("led_latency", (k >= 9 * BIT_DIV && k <= 10 * BIT_DIV + BIT_DIV / 2), 1);
        k = 0;
        while (tx !== 1'b0 && k < 2 * BIT_DIV) begin
          @(negedge clk);
          k++;
        end
        check("tx_start_latency", (k >= 1 && k <= BIT_DIV), 1);
        k = 0;
        while (tx === 1'b0 && k < 6 * BIT_DIV) begin
          @(negedge clk);
          k++;
        end
        check("tx_low_run", k, 4 * BIT_DIV);
      end
    join
    repeat (2 * BIT_DIV) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].stop) exp_q.push_back(tbl[i].data);
      send_frame(tbl[i].data, tbl[i].stop);
      rx = 1'b1;
      check($sformatf("tbl%0d_led", i), led, tbl[i].exp_led);
      repeat (2 * BIT_DIV) @(negedge clk);
    end
    drain("table_drain", 30 * BIT_DIV);

    rx = 1'b0;
    repeat (BIT_DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_DIV) @(negedge clk);
    check("glitch_led", led, 8'h80);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    check("after_glitch_led", led, 8'h5A);
    drain("glitch_drain", 30 * BIT_DIV);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = (i % 2 == 0) ? 8'h48 : 8'h47;
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      check($sformatf("stream%0d_led", i), led, b);
    end
    drain("stream_drain", 30 * BIT_DIV);

    // Reset during TX data bit 3 (bit 3 of 0xC3 is 0, so the line is low).
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    k = 0;
    while (tx !== 1'b0 && k < 2 * BIT_DIV) begin
      @(negedge clk);
      k++;
    end
    check("mid_start_seen", (k < 2 * BIT_DIV), 1);
    repeat (4 * BIT_DIV + BIT_DIV / 2) @(negedge clk);
    check("mid_bit3_low", tx, 1'b0);
    check("mid_led_before", led, 8'hC3);
    #2 rstn = 1'b0;
    #1;
    check("mid_reset_tx", tx, 1'b1);
    check("mid_reset_led", led, 8'h00);
    exp_q.delete();
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * BIT_DIV) @(negedge clk);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    check("post_reset_led", led, 8'h96);
    drain("post_reset_drain", 30 * BIT_DIV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
